// File: rtl/light_phase_sequencer.sv
// Turns DayTime's per-lane green request into timed red/yellow/green lane heads,
// enforcing minimum green, yellow clearance and an all-red gap between directions.
//
//   state   | meaning
//   ALL_RED | every lane red; waits out the clearance and then grants a valid request
//   GREEN   | pair for dir is green; holds until min green is done and another direction asks
//   YELLOW  | pair for dir is yellow; always runs to completion, then goes to ALL_RED
module light_phase_sequencer #(
  parameter int GREEN_MIN  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_lights,
  output logic [7:0] green,
  output logic [7:0] yellow,
  output logic [7:0] red,
  output logic [1:0] dir,
  output logic       green_start
);

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             req_valid;
  logic [1:0]       req_dir;

  function automatic logic [7:0] pair_mask(input logic [1:0] d);
    logic [7:0] m;
    case (d)
      2'd0:    m = 8'h03;
      2'd1:    m = 8'h0C;
      2'd2:    m = 8'h30;
      default: m = 8'hC0;
    endcase
    return m;
  endfunction

  // Only a single complete lane pair counts as a request; anything else is ignored.
  always_comb begin
    req_valid = 1'b0;
    req_dir   = 2'd0;
    case (req_lights)
      8'h03: begin req_valid = 1'b1; req_dir = 2'd0; end
      8'h0C: begin req_valid = 1'b1; req_dir = 2'd1; end
      8'h30: begin req_valid = 1'b1; req_dir = 2'd2; end
      8'hC0: begin req_valid = 1'b1; req_dir = 2'd3; end
      default: begin req_valid = 1'b0; req_dir = 2'd0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ALL_RED;
      timer       <= CNT_W'(ALLRED_CYC - 1);
      dir         <= 2'd0;
      green       <= 8'h00;
      yellow      <= 8'h00;
      red         <= 8'hFF;
      green_start <= 1'b0;
    end else begin
      green_start <= 1'b0;
      case (state)
        ALL_RED: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (req_valid) begin
            state       <= GREEN;
            dir         <= req_dir;
            timer       <= CNT_W'(GREEN_MIN - 1);
            green       <= pair_mask(req_dir);
            yellow      <= 8'h00;
            red         <= ~pair_mask(req_dir);
            green_start <= 1'b1;
          end
        end
        GREEN: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (req_valid && (req_dir != dir)) begin
            state  <= YELLOW;
            timer  <= CNT_W'(YELLOW_CYC - 1);
            green  <= 8'h00;
            yellow <= pair_mask(dir);
            red    <= ~pair_mask(dir);
          end
        end
        YELLOW: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state  <= ALL_RED;
            timer  <= CNT_W'(ALLRED_CYC - 1);
            green  <= 8'h00;
            yellow <= 8'h00;
            red    <= 8'hFF;
          end
        end
        default: begin
          state  <= ALL_RED;
          timer  <= CNT_W'(ALLRED_CYC - 1);
          green  <= 8'h00;
          yellow <= 8'h00;
          red    <= 8'hFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_phase_sequencer.sv
// Directed bench for light_phase_sequencer: timing of green/yellow/all-red phases,
// request filtering, no-abort yellow and reset mid-phase, plus per-cycle lane invariants.
module tb_light_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_lights = 8'h00;
  logic [7:0] green, yellow, red;
  logic [1:0] dir;
  logic       green_start;

  int n_checks = 0;
  int n_fail   = 0;
  bit inv_en   = 1'b0;

  light_phase_sequencer dut (
    .clk(clk), .rst(rst), .req_lights(req_lights),
    .green(green), .yellow(yellow), .red(red),
    .dir(dir), .green_start(green_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lane invariants every cycle once reset has taken effect.
  always @(negedge clk) begin
    if (inv_en) begin
      int nonred;
      nonred = 0;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (!$onehot({green[i], yellow[i], red[i]})) begin
          n_fail++;
          $display("FAIL lane_excl lane %0d: g/y/r=%b%b%b required exactly one set", i, green[i], yellow[i], red[i]);
        end
      end
      n_checks++;
      if (green != 8'h00 && yellow != 8'h00) begin
        n_fail++;
        $display("FAIL green_yellow_both: green=%h yellow=%h required one of them zero", green, yellow);
      end
      for (int p = 0; p < 4; p++)
        if (red[2*p +: 2] != 2'b11) nonred++;
      n_checks++;
      if (nonred > 1) begin
        n_fail++;
        $display("FAIL one_pair: %0d non-red pairs (red=%h) required at most 1", nonred, red);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; req_lights = 8'h00;
    step(); inv_en = 1'b1;
    step();
    n_checks++;
    if (red !== 8'hFF || green !== 8'h00 || yellow !== 8'h00 || green_start !== 1'b0 || dir !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: r=%h g=%h y=%h gs=%b dir=%0d required r=ff g=00 y=00 gs=0 dir=0", red, green, yellow, green_start, dir);
    end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      n_checks++;
      if (red !== 8'hFF || green !== 8'h00 || yellow !== 8'h00 || green_start !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_req cyc %0d: r=%h g=%h y=%h gs=%b required r=ff g=00 y=00 gs=0", c, red, green, yellow, green_start);
      end
    end
  endtask

  task automatic test_first_green();
    rst = 1'b1; req_lights = 8'h00;
    step(); step();
    rst = 1'b0; req_lights = 8'h03;
    step();
    n_checks++;
    if (red !== 8'hFF || green !== 8'h00) begin
      n_fail++;
      $display("FAIL first_allred: r=%h g=%h required r=ff g=00", red, green);
    end
    step();
    n_checks++;
    if (green !== 8'h03 || red !== 8'hFC || green_start !== 1'b1 || dir !== 2'd0) begin
      n_fail++;
      $display("FAIL first_green: g=%h r=%h gs=%b dir=%0d required g=03 r=fc gs=1 dir=0", green, red, green_start, dir);
    end
    step();
    n_checks++;
    if (green !== 8'h03 || green_start !== 1'b0) begin
      n_fail++;
      $display("FAIL gs_one_cycle: g=%h gs=%b required g=03 gs=0", green, green_start);
    end
  endtask

  task automatic test_dir_change();
    step();
    req_lights = 8'h0C;
    for (int k = 4; k <= 8; k++) begin
      step();
      n_checks++;
      if (green !== 8'h03 || yellow !== 8'h00) begin
        n_fail++;
        $display("FAIL min_green cyc %0d: g=%h y=%h required g=03 y=00", k, green, yellow);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (yellow !== 8'h03 || green !== 8'h00 || red !== 8'hFC || dir !== 2'd0) begin
        n_fail++;
        $display("FAIL yellow_n cyc %0d: y=%h g=%h r=%h dir=%0d required y=03 g=00 r=fc dir=0", k, yellow, green, red, dir);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (red !== 8'hFF || green !== 8'h00 || yellow !== 8'h00) begin
        n_fail++;
        $display("FAIL allred_gap cyc %0d: r=%h g=%h y=%h required r=ff g=00 y=00", k, red, green, yellow);
      end
    end
    step();
    n_checks++;
    if (green !== 8'h0C || red !== 8'hF3 || dir !== 2'd1 || green_start !== 1'b1) begin
      n_fail++;
      $display("FAIL green_e: g=%h r=%h dir=%0d gs=%b required g=0c r=f3 dir=1 gs=1", green, red, dir, green_start);
    end
  endtask

  task automatic test_hold();
    logic [7:0] pats [3];
    pats[0] = 8'h0F; pats[1] = 8'h01; pats[2] = 8'h00;
    rst = 1'b1; req_lights = 8'h00;
    step(); step();
    rst = 1'b0; req_lights = 8'h03;
    for (int k = 0; k < 12; k++) step();
    for (int p = 0; p < 3; p++) begin
      req_lights = pats[p];
      for (int c = 0; c < 20; c++) begin
        step();
        n_checks++;
        if (green !== 8'h03 || yellow !== 8'h00 || dir !== 2'd0 || green_start !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_green req=%h cyc %0d: g=%h y=%h dir=%0d gs=%b required g=03 y=00 dir=0 gs=0", pats[p], c, green, yellow, dir, green_start);
        end
      end
    end
  endtask

  task automatic test_no_abort();
    req_lights = 8'h0C;
    step();
    n_checks++;
    if (yellow !== 8'h03) begin
      n_fail++;
      $display("FAIL hold_exit_yellow: y=%h required 03", yellow);
    end
    for (int k = 0; k < 4; k++) step();
    step();
    n_checks++;
    if (green !== 8'h0C || green_start !== 1'b1) begin
      n_fail++;
      $display("FAIL green_e2: g=%h gs=%b required g=0c gs=1", green, green_start);
    end
    for (int k = 0; k < 7; k++) step();
    req_lights = 8'h30;
    step();
    n_checks++;
    if (yellow !== 8'h0C || dir !== 2'd1) begin
      n_fail++;
      $display("FAIL yellow_e: y=%h dir=%0d required y=0c dir=1", yellow, dir);
    end
    req_lights = 8'h0C;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (yellow !== 8'h0C || green !== 8'h00) begin
        n_fail++;
        $display("FAIL yellow_no_abort cyc %0d: y=%h g=%h required y=0c g=00", k, yellow, green);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (red !== 8'hFF || green !== 8'h00 || yellow !== 8'h00) begin
        n_fail++;
        $display("FAIL abort_allred cyc %0d: r=%h g=%h y=%h required r=ff g=00 y=00", k, red, green, yellow);
      end
    end
    step();
    n_checks++;
    if (green !== 8'h0C || dir !== 2'd1 || green_start !== 1'b1) begin
      n_fail++;
      $display("FAIL regrant_e: g=%h dir=%0d gs=%b required g=0c dir=1 gs=1", green, dir, green_start);
    end
  endtask

  task automatic test_reset_mid_yellow();
    for (int k = 0; k < 7; k++) step();
    req_lights = 8'hC0;
    step();
    n_checks++;
    if (yellow !== 8'h0C) begin
      n_fail++;
      $display("FAIL yellow_before_rst: y=%h required 0c", yellow);
    end
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (red !== 8'hFF || yellow !== 8'h00 || green !== 8'h00 || dir !== 2'd0 || green_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_yellow: r=%h y=%h g=%h dir=%0d gs=%b required r=ff y=00 g=00 dir=0 gs=0", red, yellow, green, dir, green_start);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (red !== 8'hFF || green !== 8'h00) begin
      n_fail++;
      $display("FAIL post_rst_allred: r=%h g=%h required r=ff g=00", red, green);
    end
    step();
    n_checks++;
    if (green !== 8'hC0 || red !== 8'h3F || dir !== 2'd3 || green_start !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_green_w: g=%h r=%h dir=%0d gs=%b required g=c0 r=3f dir=3 gs=1", green, red, dir, green_start);
    end
  endtask

  initial begin
    test_reset();
    test_first_green();
    test_dir_change();
    test_hold();
    test_no_abort();
    test_reset_mid_yellow();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
